friscv_dispensador: RTL and testbench
=====================================

# friscv_dispensador

Parametrised N-channel dispensing controller, the next-generation control core of the Frisc-V juice machine. It accepts one request per channel, confirms cup presence through an external ultrasonic measurement (start/finish handshake), drives exactly one pump for a fixed dose time, and aborts to an error state on a missing cup or a measurement timeout. It sits between the per-channel request buttons, the sensor datapath and the pump drivers.

## Interface
Parameters:
- N_SUCOS, 2: number of juice channels/pumps (1..8)
- LARG_MEDIDA, 12: width of the binary distance input, in cm
- DIST_COPO, 10: cup present iff 0 < medida <= DIST_COPO
- TEMPO_DOSE, 50_000_000: pump-on duration in cycles
- PERIODO_MEDIDA, 5_000_000: re-measurement period while serving, in cycles
- TIMEOUT_MEDIDA, 2_500_000: maximum wait for fim_medida, in cycles

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- liga_frisc  in  1  level enable for the machine
- liga_suco  in  N_SUCOS  per-channel request buttons, already synchronised; rising edge = request
- fim_medida  in  1  one-cycle pulse; medida is valid in that cycle
- medida  in  LARG_MEDIDA  measured distance, binary cm
- inicia_medida  out  1  one-cycle pulse that starts a measurement
- ativa_bomba  out  N_SUCOS  pump enables, at most one bit high
- pronto  out  1  one-cycle pulse when a dose completes
- erro  out  1  high while in ERRO
- db_estado  out  4  state code

## Operation
- Edge detector: registers the previous liga_suco value; reset value is all ones, so a button held through reset does not fire. Edges are taken only in ESPERA. Simultaneous edges: lowest index wins and is latched into sel. Edges in any other state are discarded.
- Moore FSM (db_estado code):
  - INICIAL(0): all outputs 0. Go to ESPERA when liga_frisc=1.
  - ESPERA(1): on an edge, latch sel and go to MEDE.
  - MEDE(2): inicia_medida=1. Clear the timeout counter. Go to AGUARDA.
  - AGUARDA(3): on fim_medida, go to SERVE if the cup is present, else ERRO. Go to ERRO if the timeout counter reaches TIMEOUT_MEDIDA-1 first.
  - SERVE(4): ativa_bomba[sel]=1. The dose counter increments. When it reaches TEMPO_DOSE-1, go to FIM. When the period counter reaches PERIODO_MEDIDA-1, go to MEDE_S.
  - MEDE_S(5): pump stays on, inicia_medida=1. Go to AGUARDA_S.
  - AGUARDA_S(6): pump stays on. On fim_medida with cup present, go to SERVE. On cup absent or timeout, go to ERRO.
  - FIM(7): pronto=1. Clear counters. Go to ESPERA.
  - ERRO(14): erro=1, pumps off.
- Global exit: liga_frisc=0 in any state other than INICIAL sends the FSM to INICIAL next cycle (pumps drop, counters clear). This has priority over every other transition, and it is the only way out of ERRO.
- Dose counter: counts in states 4/5/6 and does not pause during re-measurement. Dose completion in 5/6 also goes to FIM. Dose completion beats period expiry and cup checks in the same cycle.
- The period counter restarts on every entry to SERVE from AGUARDA or AGUARDA_S.
- medida == 0 counts as a sensor fault, i.e. cup absent.
- Counter widths are $clog2 of their terminal value, with no wrap in normal use.

## Timing
- Reset values: ativa_bomba=0, inicia_medida=0, pronto=0, erro=0, db_estado=0, sel=0, counters=0, FSM=INICIAL.
- All outputs are registered state decodes. They change on the clock edge after the causing input is sampled.
- Request at cycle t: inicia_medida high at t+1, FSM in AGUARDA at t+2.
- fim_medida with cup present sampled at cycle u: pump on from u+1.
- Pump on for exactly TEMPO_DOSE cycles total, re-measurement cycles included. pronto fires in the cycle after the pump drops.
- Timeout: ERRO is entered TIMEOUT_MEDIDA cycles after the MEDE cycle if no fim_medida arrives.
- fim_medida arriving outside AGUARDA/AGUARDA_S is ignored.

## Configuration
- FRISCV_REMEDICAO_EN defined: periodic re-measurement while serving, as above (states 5/6 reachable).
- FRISCV_REMEDICAO_EN undefined: SERVE never leaves for MEDE_S. The period counter and states 5/6 are not synthesised. The pump runs TEMPO_DOSE cycles unchecked; only the initial measurement gates the dose.

## Test plan
Use N_SUCOS=3, DIST_COPO=10, TEMPO_DOSE=20, PERIODO_MEDIDA=8, TIMEOUT_MEDIDA=16.
- Normal dose: liga_frisc=1; liga_suco=3'b010 edge; fim_medida with medida=7 → ativa_bomba=3'b010 for exactly 20 cycles (re-measures answered with 7), then pronto pulse, db_estado=1.
- Simultaneous requests: liga_suco 000→101 → sel=0, only ativa_bomba[0] asserted.
- Cup missing: medida=25, or medida=0 → ERRO (db_estado=14, erro=1, pumps 0); leaves only after liga_frisc=0 → INICIAL.
- Timeout and cup removed (macro on): no fim_medida for 16 cycles after inicia_medida → ERRO. During a dose, a re-measure answering medida=30 → pump drops and ERRO next cycle.
- Abort: liga_frisc=0 mid-dose → INICIAL next cycle, ativa_bomba=0, no pronto.
- Reset with held button: async reset asserted mid-SERVE → all outputs 0 immediately. Releasing reset with liga_suco[2]=1 held → no request until the button is released and pressed again.
- Macro off: medida=7 at start, no further fim_medida → pump stays on 20 cycles, no extra inicia_medida pulses.

Source files
------------

// File: rtl/friscv_dispensador.sv
// N-channel dispensing controller: one request per channel, ultrasonic cup check, timed pump dose.
// Optional feature: define FRISCV_REMEDICAO_EN for periodic cup re-measurement while serving.
module friscv_dispensador #(
  parameter int N_SUCOS        = 2,
  parameter int LARG_MEDIDA    = 12,
  parameter int DIST_COPO      = 10,
  parameter int TEMPO_DOSE     = 50_000_000,
  parameter int PERIODO_MEDIDA = 5_000_000,
  parameter int TIMEOUT_MEDIDA = 2_500_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   liga_frisc,
  input  logic [N_SUCOS-1:0]     liga_suco,
  input  logic                   fim_medida,
  input  logic [LARG_MEDIDA-1:0] medida,
  output logic                   inicia_medida,
  output logic [N_SUCOS-1:0]     ativa_bomba,
  output logic                   pronto,
  output logic                   erro,
  output logic [3:0]             db_estado
);

  localparam int SEL_W  = (N_SUCOS > 1)        ? $clog2(N_SUCOS)        : 1;
  localparam int DOSE_W = (TEMPO_DOSE > 1)     ? $clog2(TEMPO_DOSE)     : 1;
  localparam int TMO_W  = (TIMEOUT_MEDIDA > 1) ? $clog2(TIMEOUT_MEDIDA) : 1;

  localparam logic [DOSE_W-1:0] DOSE_FIM = DOSE_W'(TEMPO_DOSE - 1);
  localparam logic [TMO_W-1:0]  TMO_FIM  = TMO_W'(TIMEOUT_MEDIDA - 1);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    ESPERA    = 4'd1,
    MEDE      = 4'd2,
    AGUARDA   = 4'd3,
    SERVE     = 4'd4,
    MEDE_S    = 4'd5,
    AGUARDA_S = 4'd6,
    FIM       = 4'd7,
    ERRO      = 4'd14
  } estado_t;

  estado_t estado, prox;

  logic [N_SUCOS-1:0] suco_ant;
  logic [N_SUCOS-1:0] bordas;
  logic [SEL_W-1:0]   sel, sel_novo;
  logic [DOSE_W-1:0]  dose_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               copo_presente;
  logic               dose_fim;
  logic               tmo_fim;
  logic               servindo;
  logic               medindo;

  assign bordas        = liga_suco & ~suco_ant;
  assign copo_presente = (medida != '0) && (medida <= LARG_MEDIDA'(DIST_COPO));
  assign dose_fim      = (dose_cnt == DOSE_FIM);
  assign tmo_fim       = (tmo_cnt == TMO_FIM);
  assign servindo      = (estado == SERVE) || (estado == MEDE_S) || (estado == AGUARDA_S);
  // The timeout count starts in the MEDE cycle so ERRO lands TIMEOUT_MEDIDA cycles after it.
  assign medindo       = (estado == MEDE) || (estado == AGUARDA) ||
                         (estado == MEDE_S) || (estado == AGUARDA_S);

  always_comb begin
    sel_novo = '0;
    for (int i = N_SUCOS - 1; i >= 0; i--) begin
      if (bordas[i]) sel_novo = SEL_W'(i);
    end
  end

`ifdef FRISCV_REMEDICAO_EN
  localparam int PER_W = (PERIODO_MEDIDA > 1) ? $clog2(PERIODO_MEDIDA) : 1;
  localparam logic [PER_W-1:0] PER_FIM = PER_W'(PERIODO_MEDIDA - 1);

  logic [PER_W-1:0] per_cnt;
  logic             per_fim;

  assign per_fim = (per_cnt == PER_FIM);

  // Leaving SERVE clears the period count, so every re-entry restarts the period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) per_cnt <= '0;
    else        per_cnt <= (estado == SERVE) ? per_cnt + PER_W'(1) : '0;
  end
`endif

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL: if (liga_frisc) prox = ESPERA;
      ESPERA:  if (|bordas) prox = MEDE;
      MEDE:    prox = AGUARDA;
      AGUARDA: begin
        if (fim_medida)   prox = copo_presente ? SERVE : ERRO;
        else if (tmo_fim) prox = ERRO;
      end
      SERVE: begin
        if (dose_fim) prox = FIM;
`ifdef FRISCV_REMEDICAO_EN
        else if (per_fim) prox = MEDE_S;
`endif
      end
`ifdef FRISCV_REMEDICAO_EN
      MEDE_S: prox = dose_fim ? FIM : AGUARDA_S;
      AGUARDA_S: begin
        if (dose_fim)        prox = FIM;
        else if (fim_medida) prox = copo_presente ? SERVE : ERRO;
        else if (tmo_fim)    prox = ERRO;
      end
`endif
      FIM:     prox = ESPERA;
      ERRO:    prox = ERRO;
      default: prox = INICIAL;
    endcase
    if (!liga_frisc && (estado != INICIAL)) prox = INICIAL;
  end

  // Button history resets to all ones so a button held through reset never counts as a request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= INICIAL;
      suco_ant <= '1;
      sel      <= '0;
      dose_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      estado   <= prox;
      suco_ant <= liga_suco;
      if ((estado == ESPERA) && (prox == MEDE)) sel <= sel_novo;
      dose_cnt <= servindo ? dose_cnt + DOSE_W'(1) : '0;
      tmo_cnt  <= medindo  ? tmo_cnt + TMO_W'(1)   : '0;
    end
  end

  assign inicia_medida = (estado == MEDE) || (estado == MEDE_S);
  assign ativa_bomba   = servindo ? (N_SUCOS'(1) << sel) : '0;
  assign pronto        = (estado == FIM);
  assign erro          = (estado == ERRO);
  assign db_estado     = estado;

endmodule

// File: tb/tb_friscv_dispensador.sv
// Self-checking bench for friscv_dispensador: table vectors, random transactions against
// a transaction-level model, and hand-written sequences for timeout, abort and reset.
module tb_friscv_dispensador;

  localparam int NS = 3;
  localparam int DC = 10;
  localparam int TD = 20;
  localparam int PD = 8;
  localparam int TM = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          liga_frisc;
  logic [NS-1:0] liga_suco;
  logic          fim_medida;
  logic [11:0]   medida;
  logic          inicia_medida;
  logic [NS-1:0] ativa_bomba;
  logic          pronto;
  logic          erro;
  logic [3:0]    db_estado;

  int checks = 0;
  int errors = 0;

  friscv_dispensador #(
    .N_SUCOS(NS), .LARG_MEDIDA(12), .DIST_COPO(DC),
    .TEMPO_DOSE(TD), .PERIODO_MEDIDA(PD), .TIMEOUT_MEDIDA(TM)
  ) dut (
    .clock(clock), .reset(reset), .liga_frisc(liga_frisc), .liga_suco(liga_suco),
    .fim_medida(fim_medida), .medida(medida), .inicia_medida(inicia_medida),
    .ativa_bomba(ativa_bomba), .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NS-1:0] mask;
    int            lat;
    int            med;
    logic          exp_err;
    logic [NS-1:0] exp_pump;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: the winning channel is the lowest index among the new presses.
  function automatic logic [NS-1:0] lowest_bit(input logic [NS-1:0] m);
    for (int i = 0; i < NS; i++) if (m[i]) return NS'(1) << i;
    return '0;
  endfunction

  function automatic logic cup_ok(input int med);
    return (med >= 1) && (med <= DC);
  endfunction

  // Model: re-measures start PD cycles into the dose, then every PD+1+latency cycles,
  // as long as the dose (TD cycles) has not ended.
  function automatic int exp_meas(input int rlat);
    int n = 0;
`ifdef FRISCV_REMEDICAO_EN
    for (int t = PD; t <= TD - 1; t += PD + 1 + rlat) n++;
`endif
    return n;
  endfunction

  task automatic abort_to_espera();
    liga_frisc = 1'b0;
    step();
    check_output("abort_estado", db_estado, 0);
    check_output("abort_pump", ativa_bomba, 0);
    liga_frisc = 1'b1;
    step();
    check_output("rearm_estado", db_estado, 1);
  endtask

  task automatic start_req(input logic [NS-1:0] mask, input int lat, input int med);
    liga_suco = mask;
    step();
    check_output("req_inicia", inicia_medida, 1);
    check_output("req_estado", db_estado, 2);
    liga_suco = '0;
    step();
    check_output("aguarda_estado", db_estado, 3);
    repeat (lat - 1) step();
    fim_medida = 1'b1;
    medida     = 12'(med);
    step();
    fim_medida = 1'b0;
  endtask

  task automatic do_serve(input logic [NS-1:0] exp_pump, input int rlat, input int rmed,
                          input int n_meas);
    int on_cnt = 0, meas = 0, pend = 0, last_on = -1, pronto_at = -1, bad = 0;
    for (int c = 0; c < 100; c++) begin
      fim_medida = 1'b0;
      if (pronto) begin
        pronto_at = c;
        check_output("pump_off_at_pronto", ativa_bomba, 0);
        break;
      end
      if (ativa_bomba != '0) begin
        on_cnt++;
        last_on = c;
        if (ativa_bomba != exp_pump) bad++;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          fim_medida = 1'b1;
          medida     = 12'(rmed);
        end
      end
      if (inicia_medida) begin
        meas++;
        pend = rlat;
      end
      step();
    end
    fim_medida = 1'b0;
    check_output("dose_cycles", on_cnt, TD);
    check_output("dose_wrong_pump", bad, 0);
    check_output("remeasures", meas, n_meas);
    check_output("pronto_after_drop", pronto_at, last_on + 1);
    step();
    check_output("pronto_one_cycle", pronto, 0);
    check_output("back_to_espera", db_estado, 1);
  endtask

  task automatic run_txn(input logic [NS-1:0] mask, input int lat, input int med,
                         input logic exp_err, input logic [NS-1:0] exp_pump,
                         input int rlat, input int rmed);
    start_req(mask, lat, med);
    if (exp_err) begin
      check_output("err_flag", erro, 1);
      check_output("err_estado", db_estado, 14);
      check_output("err_pump", ativa_bomba, 0);
      step();
      check_output("err_sticky", db_estado, 14);
      abort_to_espera();
    end else begin
      check_output("serve_pump", ativa_bomba, exp_pump);
      check_output("serve_erro", erro, 0);
      do_serve(exp_pump, rlat, rmed, exp_meas(rlat));
    end
  endtask

  initial begin
    int n;
    logic [NS-1:0] m;
    int lat, med, rlat, rmed;

    vecs[0] = '{3'b010, 1,  7, 1'b0, 3'b010};
    vecs[1] = '{3'b101, 3,  7, 1'b0, 3'b001};
    vecs[2] = '{3'b110, 5, 10, 1'b0, 3'b010};
    vecs[3] = '{3'b100, 14, 1, 1'b0, 3'b100};
    vecs[4] = '{3'b100, 2, 25, 1'b1, 3'b000};
    vecs[5] = '{3'b011, 1,  0, 1'b1, 3'b000};
    vecs[6] = '{3'b001, 4, 11, 1'b1, 3'b000};

    reset      = 1'b0;
    liga_frisc = 1'b0;
    liga_suco  = '0;
    fim_medida = 1'b0;
    medida     = '0;
    repeat (3) @(posedge clock);
    #1;
    check_output("rst_estado", db_estado, 0);
    check_output("rst_pump", ativa_bomba, 0);
    check_output("rst_inicia", inicia_medida, 0);
    check_output("rst_pronto", pronto, 0);
    check_output("rst_erro", erro, 0);
    reset = 1'b1;
    step();
    check_output("idle_off", db_estado, 0);
    liga_frisc = 1'b1;
    step();
    check_output("enable_espera", db_estado, 1);

    fim_medida = 1'b1;
    medida     = 12'd7;
    step();
    fim_medida = 1'b0;
    check_output("stray_fim_ignored", db_estado, 1);

    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].mask, vecs[i].lat, vecs[i].med, vecs[i].exp_err, vecs[i].exp_pump, 1, 7);

    for (int i = 0; i < 12; i++) begin
      m    = NS'($urandom_range(1, 7));
      lat  = $urandom_range(1, 14);
      med  = $urandom_range(0, 20);
      rlat = $urandom_range(1, 3);
      rmed = $urandom_range(1, DC);
      run_txn(m, lat, med, !cup_ok(med), lowest_bit(m), rlat, rmed);
    end

    liga_suco = 3'b001;
    step();
    check_output("tmo_inicia", inicia_medida, 1);
    liga_suco = '0;
    n = 0;
    while (!erro && n < 40) begin
      step();
      n++;
    end
    check_output("tmo_cycles", n, TM);
    abort_to_espera();

    start_req(3'b010, 1, 7);
    check_output("abort_pump_on", ativa_bomba, 3'b010);
    repeat (5) step();
    liga_frisc = 1'b0;
    step();
    check_output("abort_mid_estado", db_estado, 0);
    check_output("abort_mid_pump", ativa_bomba, 0);
    check_output("abort_mid_pronto", pronto, 0);
    liga_frisc = 1'b1;
    step();
    check_output("abort_mid_rearm", db_estado, 1);

`ifdef FRISCV_REMEDICAO_EN
    start_req(3'b001, 2, 7);
    check_output("remove_pump_on", ativa_bomba, 3'b001);
    n = 0;
    while (!inicia_medida && n < 30) begin
      step();
      n++;
    end
    check_output("remove_remeasure_seen", inicia_medida, 1);
    step();
    fim_medida = 1'b1;
    medida     = 12'd30;
    step();
    fim_medida = 1'b0;
    check_output("remove_erro", erro, 1);
    check_output("remove_pump_off", ativa_bomba, 0);
    check_output("remove_estado", db_estado, 14);
    abort_to_espera();
`endif

    start_req(3'b100, 1, 7);
    repeat (3) step();
    check_output("rstmid_pump_on", ativa_bomba, 3'b100);
    liga_suco = 3'b100;
    #2 reset = 1'b0;
    #1;
    check_output("rstmid_pump", ativa_bomba, 0);
    check_output("rstmid_estado", db_estado, 0);
    check_output("rstmid_inicia", inicia_medida, 0);
    check_output("rstmid_pronto", pronto, 0);
    check_output("rstmid_erro", erro, 0);
    step();
    step();
    reset = 1'b1;
    step();
    n = 0;
    repeat (4) begin
      if (inicia_medida) n++;
      step();
    end
    check_output("held_no_request", n, 0);
    check_output("held_estado", db_estado, 1);
    liga_suco = '0;
    step();
    liga_suco = 3'b100;
    step();
    check_output("repress_inicia", inicia_medida, 1);
    check_output("repress_estado", db_estado, 2);
    liga_suco = '0;
    abort_to_espera();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
